// File: rtl/rvc_compressor_packer.sv
// RV32 -> RVC compressor with little-endian 16/32-bit parcel packing into 32-bit words.
// The output word register is the only output buffer; a lone compressed parcel waits in pend_reg.
module rvc_compressor_packer #(
    parameter int CNT_W           = 32,
    parameter int ENABLE_SP_FORMS = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_instr_valid,
    output logic             o_instr_ready,
    input  logic [31:0]      i_instr,
    input  logic             i_flush,
    output logic             o_flush_done,
    output logic             o_word_valid,
    input  logic             i_word_ready,
    output logic [31:0]      o_word,
    output logic             o_pending,
    output logic [CNT_W-1:0] o_compressed_count,
    output logic             o_bad_input
);
    typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic [15:0]       pend_reg, pend_next;
    logic [31:0]       word_reg;
    logic              word_valid_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              flush_done_reg, flush_done_next;
    logic              flush_seen_reg, flush_seen_next;
    logic              bad_reg;

    logic        out_free, accept, emit, cnt_inc, can_c;
    logic [31:0] emit_word;
    logic [15:0] c16;

    wire [6:0]  opcode = i_instr[6:0];
    wire [2:0]  funct3 = i_instr[14:12];
    wire [4:0]  rd     = i_instr[11:7];
    wire [4:0]  rs1    = i_instr[19:15];
    wire [4:0]  rs2    = i_instr[24:20];
    wire [11:0] imm_i  = i_instr[31:20];
    wire [11:0] imm_s  = {i_instr[31:25], i_instr[11:7]};

    wire is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
    wire is_add   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (i_instr[31:25] == 7'd0);
    wire is_lw    = (opcode == 7'b0000011) && (funct3 == 3'b010);
    wire is_sw    = (opcode == 7'b0100011) && (funct3 == 3'b010);
    wire imm6_ok  = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);
    wire rd_p     = (rd[4:3] == 2'b01);
    wire rs1_p    = (rs1[4:3] == 2'b01);
    wire rs2_p    = (rs2[4:3] == 2'b01);
    wire sp_on    = (ENABLE_SP_FORMS != 0);
    wire lw_off_c = (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'd0);
    wire sw_off_c = (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'd0);
    wire lw_off_s = (imm_i[11:8] == 4'd0) && (imm_i[1:0] == 2'd0);
    wire sw_off_s = (imm_s[11:8] == 4'd0) && (imm_s[1:0] == 2'd0);

    // SP forms are tested before C.LW/C.SW so they win whenever both could apply.
    always_comb begin
        c16   = 16'h0000;
        can_c = 1'b0;
        if (i_enable) begin
            can_c = 1'b1;
            if (is_addi && rd == 5'd0 && rs1 == 5'd0 && imm_i == 12'd0)
                c16 = 16'h0001;
            else if (is_addi && rd != 5'd0 && rd == rs1 && imm6_ok && imm_i != 12'd0)
                c16 = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
            else if (is_addi && rd != 5'd0 && rs1 == 5'd0 && imm6_ok)
                c16 = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
            else if (is_add && rd != 5'd0 && rd == rs1 && rs2 != 5'd0)
                c16 = {4'b1001, rd, rs2, 2'b10};
            else if (is_add && rd != 5'd0 && rs1 == 5'd0 && rs2 != 5'd0)
                c16 = {4'b1000, rd, rs2, 2'b10};
            else if (sp_on && is_lw && rd != 5'd0 && rs1 == 5'd2 && lw_off_s)
                c16 = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
            else if (sp_on && is_sw && rs1 == 5'd2 && sw_off_s)
                c16 = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
            else if (is_lw && rd_p && rs1_p && lw_off_c)
                c16 = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
            else if (is_sw && rs2_p && rs1_p && sw_off_c)
                c16 = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
            else
                can_c = 1'b0;
        end
    end

    assign out_free      = !word_valid_reg || i_word_ready;
    assign o_instr_ready = !i_flush && out_free;
    assign accept        = i_instr_valid && o_instr_ready;

    always_comb begin
        state_next      = state_reg;
        pend_next       = pend_reg;
        emit            = 1'b0;
        emit_word       = 32'd0;
        cnt_inc         = 1'b0;
        flush_done_next = 1'b0;
        flush_seen_next = i_flush ? flush_seen_reg : 1'b0;
        if (accept) begin
            cnt_inc = can_c;
            if (state_reg == EMPTY) begin
                if (can_c) begin
                    pend_next  = c16;
                    state_next = HALF;
                end else begin
                    emit      = 1'b1;
                    emit_word = i_instr;
                end
            end else begin
                emit = 1'b1;
                if (can_c) begin
                    emit_word  = {c16, pend_reg};
                    pend_next  = 16'h0000;
                    state_next = EMPTY;
                end else begin
                    emit_word = {i_instr[15:0], pend_reg};
                    pend_next = i_instr[31:16];
                end
            end
        end else if (i_flush && !flush_seen_reg) begin
            if (state_reg == EMPTY) begin
                flush_done_next = 1'b1;
                flush_seen_next = 1'b1;
            end else if (out_free) begin
                // Pad the lone halfword with C.NOP so the word stays decodable.
                emit            = 1'b1;
                emit_word       = {16'h0001, pend_reg};
                pend_next       = 16'h0000;
                state_next      = EMPTY;
                flush_done_next = 1'b1;
                flush_seen_next = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= EMPTY;
            pend_reg       <= 16'h0000;
            word_reg       <= 32'd0;
            word_valid_reg <= 1'b0;
            cnt_reg        <= '0;
            flush_done_reg <= 1'b0;
            flush_seen_reg <= 1'b0;
            bad_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pend_reg       <= pend_next;
            flush_done_reg <= flush_done_next;
            flush_seen_reg <= flush_seen_next;
            bad_reg        <= accept && (i_instr[1:0] != 2'b11);
            if (emit) begin
                word_reg       <= emit_word;
                word_valid_reg <= 1'b1;
            end else if (word_valid_reg && i_word_ready) begin
                word_valid_reg <= 1'b0;
            end
            if (cnt_inc && cnt_reg != '1)
                cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_word             = word_reg;
    assign o_word_valid       = word_valid_reg;
    assign o_pending          = (state_reg == HALF);
    assign o_compressed_count = cnt_reg;
    assign o_flush_done       = flush_done_reg;
    assign o_bad_input        = bad_reg;
endmodule

// File: tb/tb_rvc_compressor_packer.sv
// Directed bench for rvc_compressor_packer: encodings, packing, flush, backpressure, reset.
module tb_rvc_compressor_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'd0;
    logic        flush = 1'b0;
    logic        flush_done;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic [31:0] word;
    logic        pending;
    logic [31:0] count;
    logic        bad_input;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rvc_compressor_packer #(.CNT_W(32), .ENABLE_SP_FORMS(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
        .i_instr_valid(instr_valid), .o_instr_ready(instr_ready), .i_instr(instr),
        .i_flush(flush), .o_flush_done(flush_done),
        .o_word_valid(word_valid), .i_word_ready(word_ready), .o_word(word),
        .o_pending(pending), .o_compressed_count(count), .o_bad_input(bad_input)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] ins);
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed=ready_low expected=ready_high");
        end
        instr_valid = 1'b1;
        instr = ins;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_word", word, 32'h0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_count", count, 32'd0);
        check("rst_fdone", 32'(flush_done), 32'd0);
        check("rst_bad", 32'(bad_input), 32'd0);
        check("rst_ready", 32'(instr_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Word pair from two C.ADDI
        send(32'h00140413);
        check("pair_pend1", 32'(pending), 32'd1);
        check("pair_novalid", 32'(word_valid), 32'd0);
        send(32'h00140413);
        check("pair_word", word, 32'h04050405);
        check("pair_valid", 32'(word_valid), 32'd1);
        check("pair_pend0", 32'(pending), 32'd0);
        check("pair_count", count, 32'd2);

        // Mixed parcels then flush
        send(32'h00140413);
        send(32'h008000EF);
        check("mix_word", word, 32'h00EF0405);
        check("mix_pend", 32'(pending), 32'd1);
        check("mix_count", count, 32'd3);
        flush = 1'b1;
        #1 check("flush_rdy", 32'(instr_ready), 32'd0);
        @(negedge clk);
        check("flush_word", word, 32'h00010080);
        check("flush_valid", 32'(word_valid), 32'd1);
        check("flush_done", 32'(flush_done), 32'd1);
        check("flush_pend", 32'(pending), 32'd0);
        @(negedge clk);
        check("flush_once", 32'(flush_done), 32'd0);
        check("flush_drain", 32'(word_valid), 32'd0);
        flush = 1'b0;
        @(negedge clk);

        // Encodings
        send(32'h00B50533);
        send(32'h00452483);
        check("add_lw_word", word, 32'h4144952E);
        check("add_lw_count", count, 32'd5);
        send(32'h02040413);
        check("addi32_word", word, 32'h02040413);
        check("addi32_pend", 32'(pending), 32'd0);
        check("addi32_count", count, 32'd5);
        send(32'hFFF00293);
        send(32'h00700333);
        check("li_mv_word", word, 32'h831E52FD);
        send(32'h00812083);
        send(32'h00000013);
        check("lwsp_nop_word", word, 32'h000140A2);
        check("lwsp_nop_count", count, 32'd9);

        // Disable
        enable = 1'b0;
        send(32'h00140413);
        check("dis_word", word, 32'h00140413);
        check("dis_pend", 32'(pending), 32'd0);
        check("dis_count", count, 32'd9);
        enable = 1'b1;

        // Bad input
        send(32'h00000001);
        check("bad_pulse", 32'(bad_input), 32'd1);
        check("bad_word", word, 32'h00000001);
        @(negedge clk);
        check("bad_clear", 32'(bad_input), 32'd0);

        // Backpressure
        word_ready = 1'b0;
        send(32'h00140413);
        send(32'h008000EF);
        check("bp_word", word, 32'h00EF0405);
        instr_valid = 1'b1;
        instr = 32'h00140413;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_ready", 32'(instr_ready), 32'd0);
            @(negedge clk);
            check("bp_hold", word, 32'h00EF0405);
            check("bp_valid", 32'(word_valid), 32'd1);
            check("bp_count", count, 32'd10);
        end
        word_ready = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check("bp_next_word", word, 32'h04050080);
        check("bp_next_count", count, 32'd11);
        check("bp_next_pend", 32'(pending), 32'd0);
        @(negedge clk);

        // Reset while pending
        send(32'h00140413);
        check("pre_rst_pend", 32'(pending), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_pend", 32'(pending), 32'd0);
        check("mid_rst_valid", 32'(word_valid), 32'd0);
        check("mid_rst_count", count, 32'd0);
        rst_n = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("empty_fdone", 32'(flush_done), 32'd1);
        check("empty_fvalid", 32'(word_valid), 32'd0);
        flush = 1'b0;
        @(negedge clk);
        check("empty_fclear", 32'(flush_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rvc_compressor_packer.md
Name: rvc_compressor_packer

Overview:
- Streaming RV32 instruction compressor and parcel packer, the inverse of the fetch-side RVC expansion path.
- Accepts 32-bit instructions on a valid/ready stream and rewrites an eligible subset to 16-bit RVC encodings.
- Packs the resulting 16/32-bit parcels little-endian into 32-bit words on a registered valid/ready output.
- Used by the boot-image/trace re-encoding path and as a round-trip stimulus source for the decompressor.

Parameters:
CNT_W, 32, width of the compression statistics counter
ENABLE_SP_FORMS, 1, when 1 also emit C.LWSP/C.SWSP; when 0 those encodings fall through to C.LW/C.SW rules or stay 32-bit

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset, asynchronous, active-low
i_enable  input  1  1 = compress eligible instructions; 0 = every instruction passes as a 32-bit parcel
i_instr_valid  input  1  input instruction valid
o_instr_ready  output  1  input accepted when valid&ready
i_instr  input  32  RV32 instruction
i_flush  input  1  level request: pad and emit any pending halfword; hold until o_flush_done
o_flush_done  output  1  one-cycle pulse: flush complete
o_word_valid  output  1  packed output word valid
i_word_ready  input  1  downstream ready
o_word  output  32  packed word; [15:0] is the earlier parcel
o_pending  output  1  one halfword is held awaiting a partner
o_compressed_count  output  CNT_W  instructions emitted as 16-bit since reset, saturating
o_bad_input  output  1  one-cycle pulse: accepted i_instr[1:0]!=2'b11

Behaviour:
- Reset values: o_word_valid=0, o_word=0, o_pending=0, pending halfword=0, o_compressed_count=0, o_flush_done=0, o_bad_input=0.
- o_instr_ready = !i_flush && (!o_word_valid || i_word_ready). It is combinational and requires no input valid.
- Output register: o_word/o_word_valid load on the cycle a word completes. o_word_valid clears on a handshake with no new word.
- o_word must hold stable while o_word_valid && !i_word_ready.
- Compression rules (evaluated only when i_enable=1):
  - ADDI rd=rs1!=0, imm in [-32,31], imm!=0 -> C.ADDI.
  - ADDI x0,x0,0 -> C.NOP 16'h0001.
  - ADDI rd!=0, rs1=0, imm in [-32,31] -> C.LI.
  - ADD rd=rs1!=0, rs2!=0 -> C.ADD.
  - ADD rd!=0, rs1=0, rs2!=0 -> C.MV.
  - LW/SW with rd/rs1/rs2 in x8-x15, offset in [0,124] and multiple of 4 -> C.LW/C.SW.
  - LW rd!=0 / SW any rs2, rs1=x2, offset in [0,252] and multiple of 4 -> C.LWSP/C.SWSP (only if ENABLE_SP_FORMS).
- SP-form priority: when both SP form and C.LW/C.SW apply, the SP form wins.
- Never compressed: control flow (JAL/JALR/branches), since offsets would change, and all other opcodes.
- Packing FSM, two states:
  - EMPTY, 16-bit parcel -> store halfword, go HALF, no output.
  - EMPTY, 32-bit parcel -> emit i_instr, stay EMPTY.
  - HALF, 16-bit parcel -> emit {new16,pending}, go EMPTY.
  - HALF, 32-bit parcel -> emit {instr[15:0],pending}, store instr[31:16], stay HALF.
- Latency: a word completed by an accepted instruction is visible on o_word the next cycle.
- Flush: with i_flush=1, inputs are blocked.
  - If HALF and the output register is free: emit {16'h0001,pending}, go EMPTY, pulse o_flush_done the same edge.
  - If EMPTY: pulse o_flush_done the first cycle i_flush is sampled, with no word emitted.
  - o_flush_done pulses once per request. The next pulse requires i_flush to deassert first.
- Counter increments by 1 per accepted instruction emitted as 16-bit, and saturates at all-ones.
- Bad input: an instruction with [1:0]!=11 is treated as a non-compressible 32-bit parcel and pulses o_bad_input.
- Reset mid-operation discards the pending halfword and any unaccepted output word.

Test Plan:
- Word pair: addi x8,x8,1 (0x00140413) twice, i_word_ready=1 -> one word 0x04050405; count=2; o_pending=0 afterward.
- Mixed parcels: addi x8,x8,1 then jal x1,8 (0x008000EF) -> word 0x00EF0405 with o_pending=1; then flush -> word 0x00010080, o_flush_done pulse, o_pending=0.
- Encodings: add x10,x10,x11 (0x00B50533) + lw x9,4(x10) (0x00452483) -> word 0x4144952E. addi x8,x8,32 stays 32-bit.
- Disable: i_enable=0, addi x8,x8,1 -> word 0x00140413 emitted directly; count unchanged.
- Backpressure: hold i_word_ready=0 with a valid word -> o_word stable, o_instr_ready=0; release -> handshake, then the next input is accepted.
- Reset: assert i_rst_n=0 while o_pending=1 -> o_pending=0, o_word_valid=0, count=0. Flush after reset -> o_flush_done with no word emitted.
